mini_src_ctrl_seq: RTL and testbench

- Parametrised control-step sequencer for the Mini SRC datapath.
- Replaces hand-scripted per-instruction T0..T6 stimulus with a real FSM that fetches, decodes the IR opcode and drives datapath strobes for every supported instruction class.
- Adds a memory ready/wait handshake with timeout, a halt state, and illegal-opcode detection.
- Sits beside DataPath; its outputs connect one-to-one to the DataPath control inputs.

---
 rtl/mini_src_ctrl_seq.sv | 166 ++++++++++++++++
 tb/tb_mini_src_ctrl_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mini_src_ctrl_seq.sv
// Control-step sequencer for the Mini SRC datapath: fetch, decode and per-class execute
// sequencing with a memory ready/timeout handshake, a halt state and illegal-opcode flagging.
module mini_src_ctrl_seq #(
  parameter int DATA_W    = 32,
  parameter int ALU_CTL_W = 5,
  parameter int WAIT_MAX  = 15
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [DATA_W-1:0]    ir,
  input  logic                 mem_ready,
  output logic                 pc_out,
  output logic                 inc_pc,
  output logic                 mar_en,
  output logic                 read,
  output logic                 write,
  output logic                 mdr_en,
  output logic                 mdr_out,
  output logic                 ir_en,
  output logic                 gra,
  output logic                 grb,
  output logic                 grc,
  output logic                 r_in,
  output logic                 r_out,
  output logic                 ba_out,
  output logic                 c_out,
  output logic                 y_en,
  output logic                 z_en,
  output logic                 zlo_out,
  output logic                 zhi_out,
  output logic                 lo_en,
  output logic                 hi_en,
  output logic [ALU_CTL_W-1:0] alu_control,
  output logic [3:0]           step,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal,
  output logic                 bus_err
);
  localparam logic [3:0] S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
                         S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9;
  localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_NOP = 5'd26, OP_HALT = 5'd27;
  localparam int               CNT_W      = $clog2(WAIT_MAX + 2);
  localparam logic [CNT_W-1:0] WAIT_LIM   = CNT_W'(WAIT_MAX);
  localparam bit               TIMEOUT_EN = (WAIT_MAX != 0);
  localparam logic [ALU_CTL_W-1:0] ALU_ADD = ALU_CTL_W'(3), ALU_AND = ALU_CTL_W'(5),
                                   ALU_OR  = ALU_CTL_W'(6);

  logic [3:0]       r_state, w_next;
  logic [4:0]       r_opcode;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [4:0]       w_ir_op;
  logic             w_unused_ir;
  logic w_rtype, w_imm, w_muldiv, w_negnot, w_ld, w_st, w_ldi, w_halt, w_bad_op;
  logic w_in_wait, w_timeout, w_cnt_inc, w_last;

  assign w_ir_op     = ir[DATA_W-1 -: 5];
  assign w_unused_ir = ^ir[DATA_W-6:0];

  assign w_rtype  = (r_opcode >= 5'd3)  && (r_opcode <= 5'd11);
  assign w_imm    = (r_opcode >= 5'd12) && (r_opcode <= 5'd14);
  assign w_muldiv = (r_opcode == 5'd15) || (r_opcode == 5'd16);
  assign w_negnot = (r_opcode == 5'd17) || (r_opcode == 5'd18);
  assign w_ld     = (r_opcode == OP_LD);
  assign w_st     = (r_opcode == OP_ST);
  assign w_ldi    = (r_opcode == OP_LDI);
  assign w_halt   = (r_opcode == OP_HALT);
  assign w_bad_op = (r_opcode > 5'd18) && (r_opcode != OP_NOP) && !w_halt;

  assign w_in_wait = (r_state == S_T1) || ((r_state == S_T6) && w_ld) || ((r_state == S_T7) && w_st);
  // A ready arriving on the limit cycle beats the timeout.
  assign w_timeout = TIMEOUT_EN && w_in_wait && !mem_ready && (r_wait_cnt == WAIT_LIM);
  assign w_cnt_inc = TIMEOUT_EN && w_in_wait && !mem_ready && !w_timeout;

  // nop is recognised in T2, before the opcode register has been loaded, so it reads ir directly.
  assign w_last = ((r_state == S_T2) && (w_ir_op == OP_NOP)) ||
                  ((r_state == S_T4) && w_negnot) ||
                  ((r_state == S_T5) && (w_rtype || w_imm || w_ldi)) ||
                  ((r_state == S_T6) && w_muldiv) ||
                  ((r_state == S_T7) && w_ld) ||
                  ((r_state == S_T7) && w_st && mem_ready);

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state    <= S_IDLE;
      r_opcode   <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_T2) r_opcode <= w_ir_op;
      if (w_cnt_inc) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      else           r_wait_cnt <= '0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_T0;
      S_T0:   w_next = S_T1;
      S_T1:   if (mem_ready) w_next = S_T2; else if (w_timeout) w_next = S_IDLE;
      S_T2:   w_next = S_T3;
      S_T3:   if (w_halt) w_next = S_HALT; else if (w_bad_op) w_next = S_IDLE; else w_next = S_T4;
      S_T4:   w_next = S_T5;
      S_T5:   w_next = S_T6;
      S_T6:   if (!w_ld || mem_ready) w_next = S_T7; else if (w_timeout) w_next = S_IDLE;
      S_T7:   if (w_timeout) w_next = S_IDLE;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
    if (w_last) w_next = start ? S_T0 : S_IDLE;
  end

  always_comb begin
    {pc_out, inc_pc, mar_en, read, write, mdr_en, mdr_out, ir_en} = '0;
    {gra, grb, grc, r_in, r_out, ba_out, c_out, y_en, z_en, zlo_out, zhi_out, lo_en, hi_en} = '0;
    alu_control = '0;
    step    = r_state;
    busy    = (r_state >= S_T0) && (r_state <= S_T7);
    done    = w_last;
    illegal = (r_state == S_T3) && w_bad_op;
    bus_err = w_timeout;
    case (r_state)
      S_T0: {pc_out, mar_en, inc_pc} = 3'b111;
      S_T1: {read, mdr_en} = 2'b11;
      S_T2: {mdr_out, ir_en} = 2'b11;
      S_T3: begin
        if (w_rtype || w_imm)        {grb, r_out, y_en} = 3'b111;
        if (w_muldiv)                {gra, r_out, y_en} = 3'b111;
        if (w_ldi || w_ld || w_st)   {grb, ba_out, y_en} = 3'b111;
        if (w_negnot) begin
          {grb, r_out, z_en} = 3'b111;
          alu_control = ALU_CTL_W'(r_opcode);
        end
      end
      S_T4: begin
        if (w_rtype || w_muldiv) begin
          {grc, r_out, z_en} = {w_rtype, 2'b11};
          grb = w_muldiv;
          alu_control = ALU_CTL_W'(r_opcode);
        end
        if (w_imm || w_ldi || w_ld || w_st) begin
          {c_out, z_en} = 2'b11;
          alu_control = (r_opcode == 5'd13) ? ALU_AND : (r_opcode == 5'd14) ? ALU_OR : ALU_ADD;
        end
        if (w_negnot) {zlo_out, gra, r_in} = 3'b111;
      end
      S_T5: begin
        if (w_rtype || w_imm || w_ldi) {zlo_out, gra, r_in} = 3'b111;
        if (w_muldiv)                  {zlo_out, lo_en} = 2'b11;
        if (w_ld || w_st)              {zlo_out, mar_en} = 2'b11;
      end
      S_T6: begin
        if (w_muldiv) {zhi_out, hi_en} = 2'b11;
        if (w_ld)     {read, mdr_en} = 2'b11;
        if (w_st)     {gra, r_out, mdr_en} = 3'b111;
      end
      S_T7: begin
        if (w_ld) {mdr_out, gra, r_in} = 3'b111;
        if (w_st) write = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mini_src_ctrl_seq.sv
// Self-checking bench: per-cycle expected traces built from per-opcode step tables,
// a literal addi vector table, directed corner sequences and a randomized instruction stream.
module tb_mini_src_ctrl_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr, start, mem_ready;
  logic [31:0] ir;
  logic pc_out, inc_pc, mar_en, read, write, mdr_en, mdr_out, ir_en;
  logic gra, grb, grc, r_in, r_out, ba_out, c_out, y_en, z_en, zlo_out, zhi_out, lo_en, hi_en;
  logic [4:0] alu_control;
  logic [3:0] step;
  logic busy, done, illegal, bus_err;

  mini_src_ctrl_seq #(.DATA_W(32), .ALU_CTL_W(5), .WAIT_MAX(15)) dut (
    .clk(clk), .clr(clr), .start(start), .ir(ir), .mem_ready(mem_ready),
    .pc_out(pc_out), .inc_pc(inc_pc), .mar_en(mar_en), .read(read), .write(write),
    .mdr_en(mdr_en), .mdr_out(mdr_out), .ir_en(ir_en), .gra(gra), .grb(grb), .grc(grc),
    .r_in(r_in), .r_out(r_out), .ba_out(ba_out), .c_out(c_out), .y_en(y_en), .z_en(z_en),
    .zlo_out(zlo_out), .zhi_out(zhi_out), .lo_en(lo_en), .hi_en(hi_en),
    .alu_control(alu_control), .step(step), .busy(busy), .done(done),
    .illegal(illegal), .bus_err(bus_err)
  );

  localparam logic [20:0] B_PC = 21'(1) << 20, B_INC = 21'(1) << 19, B_MAR = 21'(1) << 18,
    B_RD = 21'(1) << 17, B_WR = 21'(1) << 16, B_MDRE = 21'(1) << 15, B_MDRO = 21'(1) << 14,
    B_IRE = 21'(1) << 13, B_GRA = 21'(1) << 12, B_GRB = 21'(1) << 11, B_GRC = 21'(1) << 10,
    B_RIN = 21'(1) << 9, B_ROUT = 21'(1) << 8, B_BA = 21'(1) << 7, B_COUT = 21'(1) << 6,
    B_YEN = 21'(1) << 5, B_ZEN = 21'(1) << 4, B_ZLO = 21'(1) << 3, B_ZHI = 21'(1) << 2,
    B_LO = 21'(1) << 1, B_HI = 21'(1);
  localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_ADD = 5'd3,
    OP_ADDI = 5'd12, OP_MUL = 5'd15, OP_NOP = 5'd26, OP_HALT = 5'd27;
  localparam logic [3:0] ST_HALT = 4'd9;

  wire [20:0] w_strb = {pc_out, inc_pc, mar_en, read, write, mdr_en, mdr_out, ir_en, gra, grb,
                        grc, r_in, r_out, ba_out, c_out, y_en, z_en, zlo_out, zhi_out, lo_en, hi_en};

  typedef struct {
    bit clr; bit start; bit mr; logic [4:0] op;
    logic [20:0] strb; logic [4:0] alu; logic [3:0] step;
    bit busy; bit done; bit ill; bit berr;
  } cyc_t;

  cyc_t q[$];
  cyc_t addi_tbl[7];
  int n_cmp = 0;
  int n_bad = 0;
  bit chained;

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic cyc_t mk(bit c, bit s, bit mr, logic [4:0] op, logic [20:0] sb,
                              logic [4:0] a, logic [3:0] st, bit bz, bit dn, bit il, bit be);
    cyc_t r;
    r.clr = c; r.start = s; r.mr = mr; r.op = op; r.strb = sb; r.alu = a; r.step = st;
    r.busy = bz; r.done = dn; r.ill = il; r.berr = be;
    return r;
  endfunction

  function automatic bit is_bad(logic [4:0] op);
    return (op > 5'd18) && (op != OP_NOP) && (op != OP_HALT);
  endfunction

  // Last control step of each instruction class (halt and undefined opcodes stop at T3).
  function automatic int last_t(logic [4:0] op);
    if (op == OP_NOP) return 2;
    if (op >= 5'd17 && op <= 5'd18) return 4;
    if (op == 5'd15 || op == 5'd16) return 6;
    if (op == OP_LD || op == OP_ST) return 7;
    if (op <= 5'd14) return 5;
    return 3;
  endfunction

  function automatic logic [20:0] exp_strb(logic [4:0] op, int t);
    bit rt, im, md, nn, mem;
    rt = op >= 5'd3 && op <= 5'd11;  im = op >= 5'd12 && op <= 5'd14;
    md = op == 5'd15 || op == 5'd16; nn = op == 5'd17 || op == 5'd18;
    mem = op == OP_LD || op == OP_ST || op == OP_LDI;
    case (t)
      0: return B_PC | B_INC | B_MAR;
      1: return B_RD | B_MDRE;
      2: return B_MDRO | B_IRE;
      3: if (rt || im) return B_GRB | B_ROUT | B_YEN;
         else if (md) return B_GRA | B_ROUT | B_YEN;
         else if (nn) return B_GRB | B_ROUT | B_ZEN;
         else if (mem) return B_GRB | B_BA | B_YEN;
      4: if (rt) return B_GRC | B_ROUT | B_ZEN;
         else if (md) return B_GRB | B_ROUT | B_ZEN;
         else if (nn) return B_ZLO | B_GRA | B_RIN;
         else if (im || mem) return B_COUT | B_ZEN;
      5: if (rt || im || op == OP_LDI) return B_ZLO | B_GRA | B_RIN;
         else if (md) return B_ZLO | B_LO;
         else if (op == OP_LD || op == OP_ST) return B_ZLO | B_MAR;
      6: if (md) return B_ZHI | B_HI;
         else if (op == OP_LD) return B_RD | B_MDRE;
         else if (op == OP_ST) return B_GRA | B_ROUT | B_MDRE;
      7: if (op == OP_LD) return B_MDRO | B_GRA | B_RIN;
         else if (op == OP_ST) return B_WR;
      default: ;
    endcase
    return '0;
  endfunction

  function automatic logic [4:0] exp_alu(logic [4:0] op, int t);
    if (t == 3 && (op == 5'd17 || op == 5'd18)) return op;
    if (t != 4) return 5'd0;
    if (op >= 5'd3 && op <= 5'd11) return op;
    if (op == 5'd15 || op == 5'd16) return op;
    if (op == 5'd13) return 5'd5;
    if (op == 5'd14) return 5'd6;
    if (op <= 5'd2 || op == 5'd12) return 5'd3;
    return 5'd0;
  endfunction

  task automatic add_idle(int n, bit go);
    for (int i = 0; i < n; i++) q.push_back(mk(1, 0, rb(), 5'd0, '0, '0, 4'd0, 0, 0, 0, 0));
    if (go) q.push_back(mk(1, 1, rb(), 5'd0, '0, '0, 4'd0, 0, 0, 0, 0));
  endtask

  // d1/d2: cycles of mem_ready=0 before ready in the fetch wait and the execute wait.
  task automatic add_instr(logic [4:0] op, int d1, int d2, bit b2b, output bit ch);
    int lt, n;
    bit w, fin, stop;
    lt = last_t(op);
    stop = is_bad(op) || op == OP_HALT;
    for (int t = 0; t <= lt; t++) begin
      w = (t == 1) || (t == 6 && op == OP_LD) || (t == 7 && op == OP_ST);
      n = w ? ((t == 1) ? d1 : d2) + 1 : 1;
      for (int k = 0; k < n; k++) begin
        fin = (t == lt) && (k == n - 1);
        q.push_back(mk(1, fin ? b2b : rb(), w ? (k == n - 1) : rb(), op, exp_strb(op, t),
                       exp_alu(op, t), 4'(t + 1), 1, fin && !stop, (t == 3) && is_bad(op), 0));
      end
    end
    ch = b2b && !stop;
  endtask

  task automatic run_q(string name);
    logic [33:0] got, exp;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      clr = q[i].clr; start = q[i].start; mem_ready = q[i].mr;
      ir = {q[i].op, 27'($urandom)};
      #1;
      got = {w_strb, alu_control, step, busy, done, illegal, bus_err};
      exp = {q[i].strb, q[i].alu, q[i].step, q[i].busy, q[i].done, q[i].ill, q[i].berr};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL %s[%0d]: got strb=%h alu=%h step=%0d busy/done/ill/berr=%b, required strb=%h alu=%h step=%0d busy/done/ill/berr=%b",
                 name, i, got[33:13], got[12:8], got[7:4], got[3:0],
                 exp[33:13], exp[12:8], exp[7:4], exp[3:0]);
      end
    end
    q.delete();
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; mem_ready = 1'b0; ir = '0;

    addi_tbl[0] = mk(1, 1, 1, OP_ADDI, '0, 5'd0, 4'd0, 0, 0, 0, 0);
    addi_tbl[1] = mk(1, 0, 1, OP_ADDI, B_PC | B_INC | B_MAR, 5'd0, 4'd1, 1, 0, 0, 0);
    addi_tbl[2] = mk(1, 0, 1, OP_ADDI, B_RD | B_MDRE, 5'd0, 4'd2, 1, 0, 0, 0);
    addi_tbl[3] = mk(1, 0, 1, OP_ADDI, B_MDRO | B_IRE, 5'd0, 4'd3, 1, 0, 0, 0);
    addi_tbl[4] = mk(1, 0, 1, OP_ADDI, B_GRB | B_ROUT | B_YEN, 5'd0, 4'd4, 1, 0, 0, 0);
    addi_tbl[5] = mk(1, 0, 1, OP_ADDI, B_COUT | B_ZEN, 5'd3, 4'd5, 1, 0, 0, 0);
    addi_tbl[6] = mk(1, 0, 1, OP_ADDI, B_ZLO | B_GRA | B_RIN, 5'd0, 4'd6, 1, 1, 0, 0);

    for (int i = 0; i < 3; i++) q.push_back(mk(0, rb(), rb(), 5'd0, '0, '0, 4'd0, 0, 0, 0, 0));
    run_q("reset");

    for (int i = 0; i < 7; i++) q.push_back(addi_tbl[i]);
    add_idle(2, 0);
    run_q("addi");

    add_idle(0, 1); add_instr(OP_MUL, 0, 0, 0, chained); add_idle(2, 0);
    run_q("mul");

    add_idle(0, 1); add_instr(OP_LD, 3, 3, 0, chained); add_idle(1, 0);
    run_q("ld_wait3");

    add_idle(0, 1); add_instr(OP_LD, 15, 15, 0, chained); add_idle(1, 0);
    run_q("ld_ready_at_limit");

    // Fetch timeout: ready never comes, bus_err on the 16th T1 cycle even with start high.
    add_idle(0, 1);
    q.push_back(mk(1, 0, 0, OP_LD, B_PC | B_INC | B_MAR, 5'd0, 4'd1, 1, 0, 0, 0));
    for (int k = 0; k < 16; k++)
      q.push_back(mk(1, k == 15, 0, OP_LD, B_RD | B_MDRE, 5'd0, 4'd2, 1, 0, 0, k == 15));
    add_idle(3, 0);
    run_q("timeout");

    add_idle(0, 1); add_instr(5'b11111, 0, 0, 1, chained); add_idle(2, 0);
    run_q("illegal");

    add_idle(0, 1); add_instr(OP_HALT, 0, 0, 1, chained);
    for (int k = 0; k < 20; k++) q.push_back(mk(1, rb(), rb(), OP_HALT, '0, '0, ST_HALT, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, OP_HALT, '0, '0, ST_HALT, 0, 0, 0, 0));
    add_idle(2, 0);
    run_q("halt");

    // Reset while st is waiting in T7, then a clean restart.
    add_idle(0, 1); add_instr(OP_ST, 0, 3, 0, chained);
    void'(q.pop_back()); void'(q.pop_back());
    q.push_back(mk(0, 0, 0, OP_ST, B_WR, 5'd0, 4'd8, 1, 0, 0, 0));
    add_idle(1, 1); add_instr(OP_ADD, 0, 0, 0, chained); add_idle(1, 0);
    run_q("st_reset");

    chained = 1'b0;
    for (int n = 0; n < 40; n++) begin
      int r;
      logic [4:0] op;
      r = $urandom_range(0, 21);
      if (r <= 18) op = 5'(r);
      else if (r == 19) op = OP_NOP;
      else if (r == 20) op = OP_LDI;
      else op = 5'($urandom_range(19, 25));
      if (!chained) add_idle($urandom_range(0, 2), 1);
      add_instr(op, $urandom_range(0, 6), $urandom_range(0, 6), rb(), chained);
    end
    add_idle(2, 0);
    run_q("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
